// File: rtl/keccak_sched_pkg.sv
// Shared types for the Keccak m55 bank scheduler:
// bank lifecycle states, stage ids and ownership helpers.
package keccak_sched_pkg;

    localparam int NBANK = 4;
    localparam int IDW   = $clog2(NBANK);
    localparam int CNTW  = $clog2(NBANK + 1);

    typedef logic [IDW-1:0]  bank_id_t;
    typedef logic [CNTW-1:0] bank_cnt_t;

    typedef enum logic [2:0] {
        FREE,
        LOADING,
        READY,
        COMPUTING,
        DONE,
        UNLOADING
    } bank_state_e;

    typedef enum logic [1:0] {
        ST_LD,
        ST_CP,
        ST_UL
    } stage_e;

    typedef enum logic {
        S_IDLE,
        S_OWN
    } own_state_e;

    function automatic bank_state_e next_owned(stage_e s);
        case (s)
            ST_LD:   return LOADING;
            ST_CP:   return COMPUTING;
            default: return UNLOADING;
        endcase
    endfunction

    function automatic bank_state_e next_released(stage_e s);
        case (s)
            ST_LD:   return READY;
            ST_CP:   return DONE;
            default: return FREE;
        endcase
    endfunction

endpackage

// File: rtl/keccak_bank_sched_if.sv
// Request/grant/done bundle between the three Keccak
// pipeline stages and the bank scheduler.
interface keccak_bank_sched_if;
    import keccak_sched_pkg::*;

    logic      ld_req;
    logic      ld_gnt;
    bank_id_t  ld_bank;
    logic      ld_done;
    logic      cp_req;
    logic      cp_gnt;
    bank_id_t  cp_bank;
    logic      cp_done;
    logic      ul_req;
    logic      ul_gnt;
    bank_id_t  ul_bank;
    logic      ul_done;
    bank_cnt_t free_cnt;
    logic      err;

    modport master (
        output ld_req, ld_done,
        output cp_req, cp_done,
        output ul_req, ul_done,
        input  ld_gnt, ld_bank,
        input  cp_gnt, cp_bank,
        input  ul_gnt, ul_bank,
        input  free_cnt, err
    );

    modport slave (
        input  ld_req, ld_done,
        input  cp_req, cp_done,
        input  ul_req, ul_done,
        output ld_gnt, ld_bank,
        output cp_gnt, cp_bank,
        output ul_gnt, ul_bank,
        output free_cnt, err
    );

endinterface

// File: rtl/sched_stage.sv
// One stage's view of the bank ring: walks its own pointer,
// claims a bank in IN_ST and hands it back in REL_ST.
module sched_stage
    import keccak_sched_pkg::*;
#(
    parameter bank_state_e IN_ST  = FREE,
    parameter bank_state_e OWN_ST = LOADING,
    parameter bank_state_e REL_ST = READY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        done,
    input  bank_state_e cur,
    output bank_id_t    ptr,
    output logic        gnt,
    output bank_id_t    bank,
    output logic        wr_en,
    output bank_id_t    wr_id,
    output bank_state_e wr_st,
    output logic        err_hit
);

    own_state_e st;
    own_state_e st_nx;
    bank_id_t   ptr_nx;
    bank_id_t   bank_nx;
    logic       take;

    // Ownership flag, ring pointer and registered grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            st   <= S_IDLE;
            ptr  <= '0;
            bank <= '0;
            gnt  <= 1'b0;
        end else begin
            st   <= st_nx;
            ptr  <= ptr_nx;
            bank <= bank_nx;
            gnt  <= take;
        end
    end

    // Claim the bank under the pointer, or release the owned one.
    always_comb begin
        st_nx   = st;
        ptr_nx  = ptr;
        bank_nx = bank;
        take    = 1'b0;
        err_hit = 1'b0;
        wr_en   = 1'b0;
        wr_id   = bank;
        wr_st   = REL_ST;
        unique case (st)
            S_IDLE: begin
                // A done while idle is a protocol slip.
                err_hit = done;
                if (req && cur == IN_ST) begin
                    take    = 1'b1;
                    st_nx   = S_OWN;
                    ptr_nx  = ptr + 1'b1;
                    bank_nx = ptr;
                    wr_en   = 1'b1;
                    wr_id   = ptr;
                    wr_st   = OWN_ST;
                end
            end
            S_OWN: begin
                if (done) begin
                    st_nx = S_IDLE;
                    wr_en = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/keccak_bank_sched.sv
// Hands the m55 state banks to load, compute and unload
// in strict ring order so blocks leave in arrival order.
module keccak_bank_sched
    import keccak_sched_pkg::*;
(
    input logic                clk,
    input logic                reset,
    keccak_bank_sched_if.slave bus
);

    bank_state_e bst [NBANK];
    bank_id_t    ld_ptr;
    bank_id_t    cp_ptr;
    bank_id_t    ul_ptr;
    logic [2:0]  wr_en;
    bank_id_t    wr_id [3];
    bank_state_e wr_st [3];
    logic [2:0]  err_hit;
    bank_cnt_t   nfree;
    bank_cnt_t   free_q;
    logic        err_q;

    sched_stage #(
        .IN_ST  (FREE),
        .OWN_ST (next_owned(ST_LD)),
        .REL_ST (next_released(ST_LD))
    ) u_ld (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.ld_req),
        .done    (bus.ld_done),
        .cur     (bst[ld_ptr]),
        .ptr     (ld_ptr),
        .gnt     (bus.ld_gnt),
        .bank    (bus.ld_bank),
        .wr_en   (wr_en[0]),
        .wr_id   (wr_id[0]),
        .wr_st   (wr_st[0]),
        .err_hit (err_hit[0])
    );

    sched_stage #(
        .IN_ST  (READY),
        .OWN_ST (next_owned(ST_CP)),
        .REL_ST (next_released(ST_CP))
    ) u_cp (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.cp_req),
        .done    (bus.cp_done),
        .cur     (bst[cp_ptr]),
        .ptr     (cp_ptr),
        .gnt     (bus.cp_gnt),
        .bank    (bus.cp_bank),
        .wr_en   (wr_en[1]),
        .wr_id   (wr_id[1]),
        .wr_st   (wr_st[1]),
        .err_hit (err_hit[1])
    );

    sched_stage #(
        .IN_ST  (DONE),
        .OWN_ST (next_owned(ST_UL)),
        .REL_ST (next_released(ST_UL))
    ) u_ul (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.ul_req),
        .done    (bus.ul_done),
        .cur     (bst[ul_ptr]),
        .ptr     (ul_ptr),
        .gnt     (bus.ul_gnt),
        .bank    (bus.ul_bank),
        .wr_en   (wr_en[2]),
        .wr_id   (wr_id[2]),
        .wr_st   (wr_st[2]),
        .err_hit (err_hit[2])
    );

    // Bank lifecycle; stage writes never share a bank because
    // each one requires a different current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBANK; i++) begin
                bst[i] <= FREE;
            end
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (wr_en[s]) begin
                    bst[wr_id[s]] <= wr_st[s];
                end
            end
        end
    end

    // Population count of FREE banks.
    always_comb begin
        nfree = '0;
        for (int i = 0; i < NBANK; i++) begin
            if (bst[i] == FREE) begin
                nfree = nfree + 1'b1;
            end
        end
    end

    // free_cnt trails the bank states by one cycle; err is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_q <= CNTW'(NBANK);
            err_q  <= 1'b0;
        end else begin
            free_q <= nfree;
            err_q  <= err_q | (|err_hit);
        end
    end

    assign bus.free_cnt = free_q;
    assign bus.err      = err_q;

endmodule
